// File: rtl/ace_core_pkg.sv
// Shared fetch-stage definitions: line geometry and fetch FSM state encoding.
package ace_core_pkg;

    localparam int FETCH_W    = 8;                 // instruction slots per line
    localparam int INST_W     = 32;                // bits per instruction slot
    localparam int LINE_BYTES = 32;                // bytes per I-cache line
    localparam int LINE_W     = FETCH_W * INST_W;  // 256-bit line
    localparam int LINE_OFFS  = $clog2(LINE_BYTES);// byte-offset bits within a line
    localparam int SLOT_W     = $clog2(FETCH_W);   // slot index bits, pc[4:2]

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ace_fetch_mask.sv
// Slot-valid mask for a line entered at slot offset_i: slots below the entry point are invalid.
module ace_fetch_mask
    import ace_core_pkg::*;
(
    input  logic [SLOT_W-1:0]  offset_i,
    output logic [FETCH_W-1:0] mask_o
);

    // Slot k is valid when k >= offset_i.
    always_comb begin
        mask_o = {FETCH_W{1'b1}} << offset_i;
    end

endmodule

// File: rtl/ace_fetch.sv
// Fetch stage: PC generation, one-outstanding I-cache line request, line slicing
// into eight registered instruction slots with a one-cycle valid pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | request line at pc to the I-cache (suppressed while flush_i)
// WAIT  | request accepted, waiting for the response line
// HOLD  | line received while decode buffer full, held until it drains
// DRAIN | flushed while a request was in flight, swallow the stale line
module ace_fetch
    import ace_core_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              instbuf_full_i,
    output logic              icache_req_o,
    output logic [ADDR_W-1:0] icache_addr_o,
    input  logic              icache_ready_i,
    input  logic              icache_rsp_vld_i,
    input  logic [LINE_W-1:0] icache_rsp_data_i,
    output logic [INST_W-1:0] inst0_o,
    output logic [INST_W-1:0] inst1_o,
    output logic [INST_W-1:0] inst2_o,
    output logic [INST_W-1:0] inst3_o,
    output logic [INST_W-1:0] inst4_o,
    output logic [INST_W-1:0] inst5_o,
    output logic [INST_W-1:0] inst6_o,
    output logic [INST_W-1:0] inst7_o,
    output logic              inst0_vld_o,
    output logic              inst1_vld_o,
    output logic              inst2_vld_o,
    output logic              inst3_vld_o,
    output logic              inst4_vld_o,
    output logic              inst5_vld_o,
    output logic              inst6_vld_o,
    output logic              inst7_vld_o
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [LINE_W-1:0]  hold_line_q;
    logic [FETCH_W-1:0] hold_mask_q;
    logic [INST_W-1:0]  inst_q [FETCH_W];
    logic [FETCH_W-1:0] vld_q;

    logic [FETCH_W-1:0] vld_d;
    logic [LINE_W-1:0]  line_d;
    logic               deliver;

    logic [FETCH_W-1:0] pc_mask;
    logic [ADDR_W-1:0]  line_base;
    logic [ADDR_W-1:0]  line_next;
    logic [ADDR_W-1:0]  redirect_pc;

    // Line address drops the byte offset; the next line wraps naturally at the top of memory.
    assign line_base   = pc_q & ~ADDR_W'(LINE_BYTES - 1);
    assign line_next   = line_base + ADDR_W'(LINE_BYTES);
    assign redirect_pc = redirect_pc_i & ~ADDR_W'(3);

    assign icache_req_o  = (state_q == ST_REQ) && !flush_i;
    assign icache_addr_o = line_base;

    ace_fetch_mask u_mask (
        .offset_i (pc_q[LINE_OFFS-1:2]),
        .mask_o   (pc_mask)
    );

    // Select what (if anything) is handed to decode at the next edge; a flush blocks delivery.
    always_comb begin
        deliver = 1'b0;
        vld_d   = '0;
        line_d  = icache_rsp_data_i;
        if (!flush_i) begin
            case (state_q)
                ST_WAIT: begin
                    if (icache_rsp_vld_i && !instbuf_full_i) begin
                        deliver = 1'b1;
                        vld_d   = pc_mask;
                    end
                end
                ST_HOLD: begin
                    if (!instbuf_full_i) begin
                        deliver = 1'b1;
                        vld_d   = hold_mask_q;
                        line_d  = hold_line_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM with PC and held-line registers; flush wins over every other event.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            hold_line_q <= '0;
            hold_mask_q <= '0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (flush_i) begin
                        pc_q <= redirect_pc;
                    end else if (icache_ready_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        pc_q    <= redirect_pc;
                        state_q <= icache_rsp_vld_i ? ST_REQ : ST_DRAIN;
                    end else if (icache_rsp_vld_i) begin
                        if (instbuf_full_i) begin
                            hold_line_q <= icache_rsp_data_i;
                            hold_mask_q <= pc_mask;
                            state_q     <= ST_HOLD;
                        end else begin
                            pc_q    <= line_next;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (flush_i) begin
                        pc_q    <= redirect_pc;
                        state_q <= ST_REQ;
                    end else if (!instbuf_full_i) begin
                        pc_q    <= line_next;
                        state_q <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // A flush that coincides with the stale response still retires the drain.
                    if (flush_i) begin
                        pc_q <= redirect_pc;
                    end
                    if (icache_rsp_vld_i) begin
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_REQ;
            endcase
        end
    end

    // Output slot registers: instructions hold between lines, valids pulse for one cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int k = 0; k < FETCH_W; k++) begin
                inst_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            if (deliver) begin
                for (int k = 0; k < FETCH_W; k++) begin
                    inst_q[k] <= line_d[k*INST_W +: INST_W];
                end
            end
        end
    end

    assign inst0_o = inst_q[0];
    assign inst1_o = inst_q[1];
    assign inst2_o = inst_q[2];
    assign inst3_o = inst_q[3];
    assign inst4_o = inst_q[4];
    assign inst5_o = inst_q[5];
    assign inst6_o = inst_q[6];
    assign inst7_o = inst_q[7];

    assign inst0_vld_o = vld_q[0];
    assign inst1_vld_o = vld_q[1];
    assign inst2_vld_o = vld_q[2];
    assign inst3_vld_o = vld_q[3];
    assign inst4_vld_o = vld_q[4];
    assign inst5_vld_o = vld_q[5];
    assign inst6_vld_o = vld_q[6];
    assign inst7_vld_o = vld_q[7];

endmodule

// File: tb/tb_ace_fetch.sv
// Directed bench for ace_fetch: per-cycle vector table plus hand-written corner sequences.
module tb_ace_fetch;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          flush_i;
    logic [31:0]   redirect_pc_i;
    logic          instbuf_full_i;
    logic          icache_req_o;
    logic [31:0]   icache_addr_o;
    logic          icache_ready_i;
    logic          icache_rsp_vld_i;
    logic [255:0]  icache_rsp_data_i;
    logic [31:0]   inst0_o, inst1_o, inst2_o, inst3_o, inst4_o, inst5_o, inst6_o, inst7_o;
    logic          inst0_vld_o, inst1_vld_o, inst2_vld_o, inst3_vld_o;
    logic          inst4_vld_o, inst5_vld_o, inst6_vld_o, inst7_vld_o;

    logic [31:0]   inst_a [8];
    logic [7:0]    vld_a;

    int checks   = 0;
    int failures = 0;
    bit outstanding = 1'b0;

    typedef struct {
        bit          rst_n;
        bit          fl;
        logic [31:0] redir;
        bit          full;
        bit          rdy;
        bit          rsp;
        logic [7:0]  tag;
        bit          e_req;
        logic [31:0] e_addr;
        logic [7:0]  e_vld;
        logic [7:0]  e_tag;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    ace_fetch dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .flush_i           (flush_i),
        .redirect_pc_i     (redirect_pc_i),
        .instbuf_full_i    (instbuf_full_i),
        .icache_req_o      (icache_req_o),
        .icache_addr_o     (icache_addr_o),
        .icache_ready_i    (icache_ready_i),
        .icache_rsp_vld_i  (icache_rsp_vld_i),
        .icache_rsp_data_i (icache_rsp_data_i),
        .inst0_o           (inst0_o),
        .inst1_o           (inst1_o),
        .inst2_o           (inst2_o),
        .inst3_o           (inst3_o),
        .inst4_o           (inst4_o),
        .inst5_o           (inst5_o),
        .inst6_o           (inst6_o),
        .inst7_o           (inst7_o),
        .inst0_vld_o       (inst0_vld_o),
        .inst1_vld_o       (inst1_vld_o),
        .inst2_vld_o       (inst2_vld_o),
        .inst3_vld_o       (inst3_vld_o),
        .inst4_vld_o       (inst4_vld_o),
        .inst5_vld_o       (inst5_vld_o),
        .inst6_vld_o       (inst6_vld_o),
        .inst7_vld_o       (inst7_vld_o)
    );

    always_comb begin
        inst_a = '{inst0_o, inst1_o, inst2_o, inst3_o, inst4_o, inst5_o, inst6_o, inst7_o};
        vld_a  = {inst7_vld_o, inst6_vld_o, inst5_vld_o, inst4_vld_o,
                  inst3_vld_o, inst2_vld_o, inst1_vld_o, inst0_vld_o};
    end

    // Tag 0 stands for the all-zero reset contents of the slots.
    function automatic logic [31:0] inst_word(input logic [7:0] tag, input int k);
        if (tag == 8'd0) return 32'h0;
        return {tag, 16'hC0DE, 8'(k)};
    endfunction

    function automatic logic [255:0] make_line(input logic [7:0] tag);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = inst_word(tag, k);
        return l;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check, then advance to the next edge.
    task automatic cyc(input string lbl, input bit rst_n, input bit fl, input logic [31:0] redir,
                       input bit full, input bit rdy, input bit rsp, input logic [7:0] tag,
                       input bit e_req, input logic [31:0] e_addr, input logic [7:0] e_vld,
                       input logic [7:0] e_tag);
        reset_n           = rst_n;
        flush_i           = fl;
        redirect_pc_i     = redir;
        instbuf_full_i    = full;
        icache_ready_i    = rdy;
        icache_rsp_vld_i  = rsp;
        icache_rsp_data_i = make_line(tag);
        #1;
        check32({lbl, " req"}, 32'(icache_req_o), 32'(e_req));
        if (e_req) check32({lbl, " addr"}, icache_addr_o, e_addr);
        check32({lbl, " vld"}, 32'(vld_a), 32'(e_vld));
        for (int k = 0; k < 8; k++)
            check32($sformatf("%s inst%0d", lbl, k), inst_a[k], inst_word(e_tag, k));
        if (rsp) begin
            check32({lbl, " rsp_without_request"}, 32'(outstanding), 32'd1);
            outstanding = 1'b0;
        end
        if (icache_req_o && rdy) outstanding = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic add(input bit rst_n, input bit fl, input logic [31:0] redir, input bit full,
                       input bit rdy, input bit rsp, input logic [7:0] tag, input bit e_req,
                       input logic [31:0] e_addr, input logic [7:0] e_vld, input logic [7:0] e_tag);
        vec_t v;
        v.rst_n = rst_n; v.fl = fl; v.redir = redir; v.full = full; v.rdy = rdy; v.rsp = rsp;
        v.tag = tag; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_tag = e_tag;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rst fl redir          full rdy rsp tag  req addr           vld    inst
        // streaming from reset, response two cycles after acceptance
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'h8000_0000, 8'h00, 0);
        add(1, 0, 32'h0,          0,   0,  0,  0,   0, 32'h0,         8'h00, 0);
        add(1, 0, 32'h0,          0,   0,  1,  1,   0, 32'h0,         8'h00, 0);
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'h8000_0020, 8'hFF, 1);
        add(1, 0, 32'h0,          0,   0,  0,  0,   0, 32'h0,         8'h00, 1);
        add(1, 0, 32'h0,          0,   0,  1,  2,   0, 32'h0,         8'h00, 1);
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'h8000_0040, 8'hFF, 2);
        add(1, 0, 32'h0,          0,   0,  0,  0,   0, 32'h0,         8'h00, 2);
        add(1, 0, 32'h0,          0,   0,  1,  3,   0, 32'h0,         8'h00, 2);
        add(1, 0, 32'h0,          0,   0,  0,  0,   1, 32'h8000_0060, 8'hFF, 3);
        // flush in REQ to a mid-line PC
        add(1, 1, 32'h8000_0114,  0,   1,  0,  0,   0, 32'h0,         8'h00, 3);
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'h8000_0100, 8'h00, 3);
        add(1, 0, 32'h0,          0,   0,  0,  0,   0, 32'h0,         8'h00, 3);
        add(1, 0, 32'h0,          0,   0,  1,  4,   0, 32'h0,         8'h00, 3);
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'h8000_0120, 8'hE0, 4);
        add(1, 0, 32'h0,          0,   0,  0,  0,   0, 32'h0,         8'h00, 4);
        add(1, 0, 32'h0,          0,   0,  1,  5,   0, 32'h0,         8'h00, 4);
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'h8000_0140, 8'hFF, 5);
        // decode buffer full when the response lands, held three cycles
        add(1, 0, 32'h0,          1,   0,  0,  0,   0, 32'h0,         8'h00, 5);
        add(1, 0, 32'h0,          1,   0,  1,  6,   0, 32'h0,         8'h00, 5);
        add(1, 0, 32'h0,          1,   1,  0,  0,   0, 32'h0,         8'h00, 5);
        add(1, 0, 32'h0,          1,   1,  0,  0,   0, 32'h0,         8'h00, 5);
        add(1, 0, 32'h0,          0,   1,  0,  0,   0, 32'h0,         8'h00, 5);
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'h8000_0160, 8'hFF, 6);
        // flush in WAIT, stale response four cycles later
        add(1, 1, 32'h8000_0300,  0,   0,  0,  0,   0, 32'h0,         8'h00, 6);
        add(1, 0, 32'h0,          0,   1,  0,  0,   0, 32'h0,         8'h00, 6);
        add(1, 0, 32'h0,          0,   1,  0,  0,   0, 32'h0,         8'h00, 6);
        add(1, 0, 32'h0,          0,   1,  0,  0,   0, 32'h0,         8'h00, 6);
        add(1, 0, 32'h0,          0,   1,  1,  7,   0, 32'h0,         8'h00, 6);
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'h8000_0300, 8'h00, 6);
        add(1, 0, 32'h0,          0,   0,  0,  0,   0, 32'h0,         8'h00, 6);
        // flush coincident with the response
        add(1, 1, 32'h8000_0400,  0,   0,  1,  8,   0, 32'h0,         8'h00, 6);
        add(1, 0, 32'h0,          0,   0,  0,  0,   1, 32'h8000_0400, 8'h00, 6);
        // redirect to the last line, next line wraps to zero
        add(1, 1, 32'hFFFF_FFE0,  0,   1,  0,  0,   0, 32'h0,         8'h00, 6);
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'hFFFF_FFE0, 8'h00, 6);
        add(1, 0, 32'h0,          0,   0,  0,  0,   0, 32'h0,         8'h00, 6);
        add(1, 0, 32'h0,          0,   0,  1,  9,   0, 32'h0,         8'h00, 6);
        add(1, 0, 32'h0,          0,   1,  0,  0,   1, 32'h0000_0000, 8'hFF, 9);
        // reset in WAIT, then a late response is ignored
        add(1, 0, 32'h0,          0,   0,  0,  0,   0, 32'h0,         8'h00, 9);
        add(0, 0, 32'h0,          0,   0,  0,  0,   0, 32'h0,         8'h00, 9);
        add(1, 0, 32'h0,          0,   0,  1, 10,   1, 32'h8000_0000, 8'h00, 0);
        add(1, 0, 32'h0,          0,   0,  0,  0,   1, 32'h8000_0000, 8'h00, 0);

        reset_n           = 1'b0;
        flush_i           = 1'b0;
        redirect_pc_i     = '0;
        instbuf_full_i    = 1'b0;
        icache_ready_i    = 1'b0;
        icache_rsp_vld_i  = 1'b0;
        icache_rsp_data_i = '0;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc($sformatf("v%0d", i), vecs[i].rst_n, vecs[i].fl, vecs[i].redir, vecs[i].full,
                vecs[i].rdy, vecs[i].rsp, vecs[i].tag, vecs[i].e_req, vecs[i].e_addr,
                vecs[i].e_vld, vecs[i].e_tag);
        end

        // held line dropped by a flush, redirect to slot 2
        cyc("hold_acc",   1, 0, 32'h0,         0, 1, 0, 0,  1, 32'h8000_0000, 8'h00, 0);
        cyc("hold_wait",  1, 0, 32'h0,         0, 0, 0, 0,  0, 32'h0,         8'h00, 0);
        cyc("hold_rsp",   1, 0, 32'h0,         1, 0, 1, 11, 0, 32'h0,         8'h00, 0);
        cyc("hold_flush", 1, 1, 32'h8000_0208, 1, 0, 0, 0,  0, 32'h0,         8'h00, 0);
        cyc("hold_req",   1, 0, 32'h0,         0, 1, 0, 0,  1, 32'h8000_0200, 8'h00, 0);
        cyc("hold_wait2", 1, 0, 32'h0,         0, 0, 0, 0,  0, 32'h0,         8'h00, 0);
        cyc("hold_rsp2",  1, 0, 32'h0,         0, 0, 1, 12, 0, 32'h0,         8'h00, 0);
        cyc("hold_dlv",   1, 0, 32'h0,         0, 1, 0, 0,  1, 32'h8000_0220, 8'hFC, 12);

        // two flushes while draining, last redirect wins
        cyc("drn_fl1",    1, 1, 32'h8000_0500, 0, 0, 0, 0,  0, 32'h0,         8'h00, 12);
        cyc("drn_fl2",    1, 1, 32'h8000_0604, 0, 0, 0, 0,  0, 32'h0,         8'h00, 12);
        cyc("drn_idle",   1, 0, 32'h0,         0, 1, 0, 0,  0, 32'h0,         8'h00, 12);
        cyc("drn_stale",  1, 0, 32'h0,         0, 1, 1, 13, 0, 32'h0,         8'h00, 12);
        cyc("drn_req",    1, 0, 32'h0,         0, 1, 0, 0,  1, 32'h8000_0600, 8'h00, 12);
        cyc("drn_wait",   1, 0, 32'h0,         0, 0, 0, 0,  0, 32'h0,         8'h00, 12);
        cyc("drn_rsp",    1, 0, 32'h0,         0, 0, 1, 14, 0, 32'h0,         8'h00, 12);
        cyc("drn_dlv",    1, 0, 32'h0,         0, 0, 0, 0,  1, 32'h8000_0620, 8'hFE, 14);
        cyc("drn_after",  1, 0, 32'h0,         0, 0, 0, 0,  1, 32'h8000_0620, 8'h00, 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
